atm_pin_auth: RTL and testbench

- Authentication stage directly upstream of the ATM transaction FSM.
- Captures card insertion, account ID and PIN entry, and checks them against an internal per-account PIN table.
- Counts wrong attempts and locks accounts; hands the FSM a registered grant plus account index.
- Owns the PIN table, so the FSM's change-PIN operation writes through this block.

---
 rtl/atm_pin_auth.sv | 222 ++++++++++++++++++++++
 tb/tb_atm_pin_auth.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_pin_auth.sv
// atm_pin_auth: card / PIN authentication stage in front of the ATM transaction FSM.
// Holds the per-account PIN table and lock bits, counts wrong attempts, and hands
// a registered grant plus account index downstream.
// Optional WAIT_PIN idle timeout is compiled in when ATM_AUTH_TIMEOUT_EN is defined.
module atm_pin_auth #(
  parameter int NUM_ACCOUNTS = 4,
  parameter int ID_W         = 4,
  parameter int PIN_W        = 4,
  parameter int MAX_TRIES    = 3,
  parameter int TIMEOUT_CYC  = 1000,
  localparam int IDX_W       = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             card_inserted,
  input  logic [ID_W-1:0]  account_id,
  input  logic [PIN_W-1:0] pin_in,
  input  logic             pin_valid,
  input  logic             exit_req,
  input  logic             pin_wr,
  input  logic [PIN_W-1:0] new_pin,
  output logic             auth_ok,
  output logic             auth_fail,
  output logic             card_locked,
  output logic [IDX_W-1:0] acct_idx,
  output logic [1:0]       tries_left,
  output logic             timeout
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PIN = 3'd1,
    S_CHECK    = 3'd2,
    S_GRANTED  = 3'd3,
    S_LOCKED   = 3'd4
  } state_t;

  localparam logic [1:0] TRIES_INIT = 2'(MAX_TRIES);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [PIN_W-1:0]   pin_q, pin_d;
  logic [1:0]         tries_q, tries_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               auth_ok_q, auth_ok_d;
  logic               auth_fail_q, auth_fail_d;
  logic               locked_q, locked_d;
  logic               timeout_q, timeout_d;
  logic [PIN_W-1:0]   pin_tbl_q [NUM_ACCOUNTS];
  logic [PIN_W-1:0]   pin_tbl_d [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock_q, lock_d;

  // Table search results for the latched ID/PIN
  logic               hit_s;
  logic [IDX_W-1:0]   hit_idx_s;
  logic               id_hit_s;
  logic [IDX_W-1:0]   id_idx_s;

`ifdef ATM_AUTH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
`else
  // Timeout disabled: the parameter is kept for interface compatibility only.
  logic [31:0]        unused_timeout_cyc_s;
  assign unused_timeout_cyc_s = 32'(TIMEOUT_CYC);
`endif

  // Account ID stored in table entry i (fixed mapping: entry i holds ID i).
  function automatic logic [ID_W-1:0] acct_id(input int i);
    return ID_W'(i);
  endfunction

  // Power-up PIN of table entry i.
  function automatic logic [PIN_W-1:0] default_pin(input int i);
    return PIN_W'(i);
  endfunction

  // Parallel search of every table entry against the latched ID/PIN (IDs are unique).
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = {IDX_W{1'b0}};
    id_hit_s  = 1'b0;
    id_idx_s  = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_ACCOUNTS; i++) begin
      hit_s     = hit_s | ((id_q == acct_id(i)) & (pin_q == pin_tbl_q[i]) & ~lock_q[i]);
      hit_idx_s = hit_idx_s |
                  (((id_q == acct_id(i)) & (pin_q == pin_tbl_q[i]) & ~lock_q[i]) ?
                   IDX_W'(i) : {IDX_W{1'b0}});
      id_hit_s  = id_hit_s | (id_q == acct_id(i));
      id_idx_s  = id_idx_s | ((id_q == acct_id(i)) ? IDX_W'(i) : {IDX_W{1'b0}});
    end
  end

  // Next-state, table update and next-output computation.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    pin_d       = pin_q;
    tries_d     = tries_q;
    idx_d       = idx_q;
    auth_fail_d = 1'b0;
    timeout_d   = 1'b0;
    pin_tbl_d   = pin_tbl_q;
    lock_d      = lock_q;
`ifdef ATM_AUTH_TIMEOUT_EN
    tmo_cnt_d   = {TMO_W{1'b0}};
`endif
    if (!card_inserted) begin
      // Card removal dominates: any pending CHECK is dropped without lock update.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT_PIN;
          tries_d = TRIES_INIT;
        end
        S_WAIT_PIN: begin
          if (exit_req) begin
            state_d = S_IDLE;
          end else if (pin_valid) begin
            id_d    = account_id;
            pin_d   = pin_in;
            state_d = S_CHECK;
          end else begin
`ifdef ATM_AUTH_TIMEOUT_EN
            if (tmo_cnt_q == TMO_LAST) begin
              timeout_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
`else
            state_d = S_WAIT_PIN;
`endif
          end
        end
        S_CHECK: begin
          if (hit_s) begin
            state_d = S_GRANTED;
            idx_d   = hit_idx_s;
          end else begin
            auth_fail_d = 1'b1;
            tries_d     = (tries_q == 2'd0) ? 2'd0 : (tries_q - 2'd1);
            if (tries_q <= 2'd1) begin
              // Lock only the account whose ID was presented; unknown IDs lock nothing.
              lock_d[id_idx_s] = lock_q[id_idx_s] | id_hit_s;
              state_d          = S_LOCKED;
            end else begin
              state_d = S_WAIT_PIN;
            end
          end
        end
        S_GRANTED: begin
          if (pin_wr) begin
            pin_tbl_d[idx_q] = new_pin;
          end else begin
            pin_tbl_d[idx_q] = pin_tbl_q[idx_q];
          end
          if (exit_req) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GRANTED;
          end
        end
        S_LOCKED: begin
          state_d = S_LOCKED;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    auth_ok_d = (state_d == S_GRANTED);
    locked_d  = (state_d == S_LOCKED);
  end

  // FSM state, session registers, PIN/lock tables and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      id_q        <= {ID_W{1'b0}};
      pin_q       <= {PIN_W{1'b0}};
      tries_q     <= TRIES_INIT;
      idx_q       <= {IDX_W{1'b0}};
      auth_ok_q   <= 1'b0;
      auth_fail_q <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      lock_q      <= {NUM_ACCOUNTS{1'b0}};
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        pin_tbl_q[i] <= default_pin(i);
      end
`ifdef ATM_AUTH_TIMEOUT_EN
      tmo_cnt_q   <= {TMO_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      pin_q       <= pin_d;
      tries_q     <= tries_d;
      idx_q       <= idx_d;
      auth_ok_q   <= auth_ok_d;
      auth_fail_q <= auth_fail_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      lock_q      <= lock_d;
      pin_tbl_q   <= pin_tbl_d;
`ifdef ATM_AUTH_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign auth_ok     = auth_ok_q;
  assign auth_fail   = auth_fail_q;
  assign card_locked = locked_q;
  assign acct_idx    = idx_q;
  assign tries_left  = tries_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_atm_pin_auth.sv
// tb_atm_pin_auth: directed bench for atm_pin_auth with a session-level reference model.
module tb_atm_pin_auth;
  localparam int NA = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       card_inserted;
  logic [3:0] account_id;
  logic [3:0] pin_in;
  logic       pin_valid;
  logic       exit_req;
  logic       pin_wr;
  logic [3:0] new_pin;
  logic       auth_ok;
  logic       auth_fail;
  logic       card_locked;
  logic [1:0] acct_idx;
  logic [1:0] tries_left;
  logic       timeout;

  atm_pin_auth dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .card_inserted(card_inserted),
    .account_id   (account_id),
    .pin_in       (pin_in),
    .pin_valid    (pin_valid),
    .exit_req     (exit_req),
    .pin_wr       (pin_wr),
    .new_pin      (new_pin),
    .auth_ok      (auth_ok),
    .auth_fail    (auth_fail),
    .card_locked  (card_locked),
    .acct_idx     (acct_idx),
    .tries_left   (tries_left),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: account table plus expected session outputs
  int m_pin  [NA];
  bit m_lock [NA];
  bit e_ok;
  bit e_fail;
  bit e_locked;
  int e_tries;
  int e_idx;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      m_pin[i]  = i;
      m_lock[i] = 1'b0;
    end
    e_ok = 1'b0; e_fail = 1'b0; e_locked = 1'b0; e_tries = 3; e_idx = 0;
  endtask

  // Compare the DUT against the model every cycle, mid-period
  always @(negedge clk) begin
    check("auth_ok", int'(auth_ok), int'(e_ok));
    check("auth_fail", int'(auth_fail), int'(e_fail));
    check("card_locked", int'(card_locked), int'(e_locked));
    check("tries_left", int'(tries_left), e_tries);
    check("timeout", int'(timeout), 0);
    if (e_ok) check("acct_idx", int'(acct_idx), e_idx);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    e_fail = 1'b0;
  endtask

  task automatic insert();
    card_inserted = 1'b1;
    tick();
    e_tries = 3;
  endtask

  task automatic remove();
    card_inserted = 1'b0;
    tick();
    e_ok = 1'b0;
    e_locked = 1'b0;
  endtask

  // Rules of a completed PIN check, from the account table
  task automatic model_check(input int id, input int pin);
    int old;
    if (id < NA && m_pin[id] == pin && !m_lock[id]) begin
      e_ok  = 1'b1;
      e_idx = id;
    end else begin
      e_fail  = 1'b1;
      old     = e_tries;
      e_tries = (old > 0) ? old - 1 : 0;
      if (old <= 1) begin
        if (id < NA) m_lock[id] = 1'b1;
        e_locked = 1'b1;
      end
    end
  endtask

  task automatic enter_pin(input int id, input int pin);
    account_id = 4'(id);
    pin_in     = 4'(pin);
    pin_valid  = 1'b1;
    tick();
    pin_valid  = 1'b0;
    tick();
    model_check(id, pin);
  endtask

  // Exit with card still present: IDLE, then straight back into WAIT_PIN
  task automatic exit_session();
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    e_ok = 1'b0;
    tick();
    e_tries = 3;
  endtask

  task automatic pin_change(input int p);
    pin_wr  = 1'b1;
    new_pin = 4'(p);
    tick();
    pin_wr  = 1'b0;
    if (e_ok) m_pin[e_idx] = p;
  endtask

  initial begin
    rst_n = 1'b0; card_inserted = 1'b0; account_id = 4'd0; pin_in = 4'd0;
    pin_valid = 1'b0; exit_req = 1'b0; pin_wr = 1'b0; new_pin = 4'd0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("reset_tries", int'(tries_left), 3);
    check("reset_ok", int'(auth_ok), 0);

    // Correct PIN grants two cycles after the strobe
    insert();
    enter_pin(2, 2);
    check("grant2_ok", int'(auth_ok), 1);
    check("grant2_idx", int'(acct_idx), 2);
    check("grant2_tries", int'(tries_left), 3);
    exit_session();
    remove();

    // Three wrong PINs lock account 1
    insert();
    enter_pin(1, 5);
    check("wrong1_fail", int'(auth_fail), 1);
    check("wrong1_tries", int'(tries_left), 2);
    enter_pin(1, 5);
    check("wrong2_tries", int'(tries_left), 1);
    enter_pin(1, 5);
    check("wrong3_tries", int'(tries_left), 0);
    check("wrong3_locked", int'(card_locked), 1);
    tick(); tick();
    check("locked_holds", int'(card_locked), 1);
    remove();
    check("unlock_on_remove", int'(card_locked), 0);
    insert();
    enter_pin(1, 1);
    check("locked_acct_fail", int'(auth_fail), 1);
    check("locked_acct_no_ok", int'(auth_ok), 0);
    check("locked_acct_tries", int'(tries_left), 2);
    remove();

    // Change PIN on account 3 through the grant
    insert();
    enter_pin(3, 3);
    check("grant3_idx", int'(acct_idx), 3);
    pin_change(9);
    check("pinwr_still_ok", int'(auth_ok), 1);
    exit_session();
    remove();
    insert();
    enter_pin(3, 3);
    check("old_pin_fail", int'(auth_fail), 1);
    enter_pin(3, 9);
    check("new_pin_ok", int'(auth_ok), 1);
    check("new_pin_idx", int'(acct_idx), 3);
    exit_session();
    remove();

    // pin_valid together with exit_req: exit wins
    insert();
    enter_pin(0, 7);
    account_id = 4'd0; pin_in = 4'd0; pin_valid = 1'b1; exit_req = 1'b1;
    tick();
    pin_valid = 1'b0; exit_req = 1'b0;
    check("exitwin_tries", int'(tries_left), 2);
    check("exitwin_nofail", int'(auth_fail), 0);
    tick();
    e_tries = 3;
    check("exitwin_no_grant", int'(auth_ok), 0);
    check("exitwin_reload", int'(tries_left), 3);

    // Card pulled during the CHECK of the third wrong PIN
    enter_pin(0, 7);
    enter_pin(0, 7);
    check("pre_pull_tries", int'(tries_left), 1);
    account_id = 4'd0; pin_in = 4'd7; pin_valid = 1'b1;
    tick();
    pin_valid = 1'b0; card_inserted = 1'b0;
    tick();
    e_ok = 1'b0; e_locked = 1'b0;
    check("pull_not_locked", int'(card_locked), 0);
    check("pull_nofail", int'(auth_fail), 0);
    check("pull_tries", int'(tries_left), 1);
    insert();
    pin_change(6);
    enter_pin(0, 0);
    check("pull_acct_ok", int'(auth_ok), 1);
    check("pull_acct_idx", int'(acct_idx), 0);

    // Asynchronous reset mid-session restores tables and lock bits
    rst_n = 1'b0; card_inserted = 1'b0;
    model_reset();
    #1;
    check("async_rst_ok", int'(auth_ok), 0);
    check("async_rst_tries", int'(tries_left), 3);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    insert();
    enter_pin(9, 9);
    check("unknown_id_fail", int'(auth_fail), 1);
    enter_pin(1, 1);
    check("relock_cleared_ok", int'(auth_ok), 1);
    check("relock_cleared_idx", int'(acct_idx), 1);
    exit_session();
    enter_pin(3, 3);
    check("pin_reverted_ok", int'(auth_ok), 1);
    check("pin_reverted_idx", int'(acct_idx), 3);
    remove();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
